mips_wb_stage: RTL and testbench

MEM/WB pipeline register and load-alignment unit for the pipelined MIPS core. It sits directly upstream of the register file and captures the MEM-stage result on each rising clock edge. It aligns and extends load data (LB/LBU/LH/LHU/LW/LWL/LWR), and drives the register file's address, data and 4-bit byte-write-enable inputs. It also provides a merged forwarding value and a retired-instruction counter.

---
 rtl/mips_wb_pkg.sv | 31 +++
 rtl/mips_load_align.sv | 69 ++++++
 rtl/mips_wb_stage.sv | 100 ++++++++++
 tb/tb_mips_wb_stage.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_wb_pkg.sv
// Shared types and helpers for the MIPS MEM/WB stage.
// Load-type encoding is fixed; the byte-merge helper serves the LWL/LWR forwarding path.
package mips_wb_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int EN_W   = 4;

  typedef enum logic [2:0] {
    LOAD_NONE = 3'd0,
    LB        = 3'd1,
    LBU       = 3'd2,
    LH        = 3'd3,
    LHU       = 3'd4,
    LW        = 3'd5,
    LWL       = 3'd6,
    LWR       = 3'd7
  } load_type_t;

  // Byte i of the result comes from new_data when en[i] is set, else from old_data.
  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] new_data,
                                                    input logic [DATA_W-1:0] old_data,
                                                    input logic [EN_W-1:0]   en);
    logic [DATA_W-1:0] result;
    for (int i = 0; i < EN_W; i++) begin
      result[8*i +: 8] = en[i] ? new_data[8*i +: 8] : old_data[8*i +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/mips_load_align.sv
// Combinational load alignment/extension for big-endian data memory.
// LWL/LWR are only decoded when MIPS_WB_LWLR_EN is defined; otherwise they write nothing.
module mips_load_align
  import mips_wb_pkg::*;
(
  input  load_type_t        load_type,
  input  logic [1:0]        off,
  input  logic [DATA_W-1:0] rdata,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              reg_write,
  output logic [DATA_W-1:0] data,
  output logic [EN_W-1:0]   byte_en
);

  logic [DATA_W-1:0] byte_shift;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;

  // Byte at offset off sits at bits [31-8*off -: 8]; shifting right by 8*(3-off) brings it to [7:0].
  assign byte_shift = rdata >> {~off, 3'b000};
  assign byte_sel   = byte_shift[7:0];
  assign half_sel   = off[1] ? rdata[15:0] : rdata[31:16];

  always_comb begin
    data    = '0;
    byte_en = '0;
    case (load_type)
      LOAD_NONE: begin
        data    = alu_result;
        byte_en = reg_write ? 4'b1111 : 4'b0000;
      end
      LB: begin
        data    = {{24{byte_sel[7]}}, byte_sel};
        byte_en = 4'b1111;
      end
      LBU: begin
        data    = {24'd0, byte_sel};
        byte_en = 4'b1111;
      end
      LH: begin
        data    = {{16{half_sel[15]}}, half_sel};
        byte_en = 4'b1111;
      end
      LHU: begin
        data    = {16'd0, half_sel};
        byte_en = 4'b1111;
      end
      LW: begin
        data    = rdata;
        byte_en = 4'b1111;
      end
`ifdef MIPS_WB_LWLR_EN
      LWL: begin
        data    = rdata << {off, 3'b000};
        byte_en = 4'b1111 << off;
      end
      LWR: begin
        data    = rdata >> {~off, 3'b000};
        byte_en = 4'b1111 >> ~off;
      end
`endif
      default: begin
        data    = '0;
        byte_en = '0;
      end
    endcase
  end

endmodule

// File: rtl/mips_wb_stage.sv
// MEM/WB pipeline register: load alignment, write-once byte enables, forwarding merge, retire counter.
// Define MIPS_WB_LWLR_EN to enable LWL/LWR and the partial-word forwarding merge.
module mips_wb_stage
  import mips_wb_pkg::*;
(
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Mem_valid,
  input  logic [2:0]        Mem_load_type,
  input  logic              Mem_reg_write,
  input  logic [ADDR_W-1:0] Mem_rd_addr,
  input  logic [DATA_W-1:0] Mem_alu_result,
  input  logic [DATA_W-1:0] Mem_rdata,
  input  logic [DATA_W-1:0] Mem_rt_old,
  input  logic              Stall,
  input  logic              Flush,
  output logic [ADDR_W-1:0] Rd_addr,
  output logic [DATA_W-1:0] Rd_in,
  output logic [EN_W-1:0]   Rd_write_byte_en,
  output logic              Fwd_valid,
  output logic [ADDR_W-1:0] Fwd_addr,
  output logic [DATA_W-1:0] Fwd_data,
  output logic [DATA_W-1:0] Wb_count
);

  logic [DATA_W-1:0] align_data;
  logic [EN_W-1:0]   align_en;
  logic [EN_W-1:0]   en_next;

  logic              valid_reg;
  logic              written_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] data_reg;
  logic [EN_W-1:0]   en_reg;
  logic [DATA_W-1:0] count_reg;

  mips_load_align u_align (
    .load_type  (load_type_t'(Mem_load_type)),
    .off        (Mem_alu_result[1:0]),
    .rdata      (Mem_rdata),
    .alu_result (Mem_alu_result),
    .reg_write  (Mem_reg_write),
    .data       (align_data),
    .byte_en    (align_en)
  );

  // $zero is never written.
  assign en_next = (Mem_rd_addr == '0) ? '0 : align_en;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      valid_reg   <= 1'b0;
      written_reg <= 1'b0;
      addr_reg    <= '0;
      data_reg    <= '0;
      en_reg      <= '0;
      count_reg   <= '0;
    end else if (Stall) begin
      // A held entry has already been presented once; suppress repeat writes.
      if (valid_reg) written_reg <= 1'b1;
    end else if (Flush) begin
      valid_reg   <= 1'b0;
      written_reg <= 1'b0;
    end else begin
      valid_reg   <= Mem_valid;
      written_reg <= 1'b0;
      addr_reg    <= Mem_rd_addr;
      data_reg    <= align_data;
      en_reg      <= en_next;
      if (Mem_valid) count_reg <= count_reg + 32'd1;
    end
  end

  assign Rd_addr          = addr_reg;
  assign Rd_in            = data_reg;
  assign Rd_write_byte_en = (valid_reg && !written_reg) ? en_reg : '0;
  assign Fwd_valid        = valid_reg && (en_reg != '0);
  assign Fwd_addr         = addr_reg;
  assign Wb_count         = count_reg;

`ifdef MIPS_WB_LWLR_EN
  logic [DATA_W-1:0] rt_old_reg;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rt_old_reg <= '0;
    end else if (!Stall && !Flush) begin
      rt_old_reg <= Mem_rt_old;
    end
  end

  assign Fwd_data = merge_bytes(data_reg, rt_old_reg, en_reg);
`else
  // Without partial-word loads the enables are all-or-nothing, so the old value is never needed.
  logic [DATA_W-1:0] unused_rt_old;
  assign unused_rt_old = Mem_rt_old;
  assign Fwd_data      = data_reg;
`endif

endmodule

// File: tb/tb_mips_wb_stage.sv
// Self-checking bench for mips_wb_stage: directed literal cases plus randomized traffic
// compared every cycle against an entry/age-based reference model.
module tb_mips_wb_stage;
  import mips_wb_pkg::*;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        Mem_valid = 1'b0;
  logic [2:0]  Mem_load_type = 3'd0;
  logic        Mem_reg_write = 1'b0;
  logic [4:0]  Mem_rd_addr = 5'd0;
  logic [31:0] Mem_alu_result = 32'd0;
  logic [31:0] Mem_rdata = 32'd0;
  logic [31:0] Mem_rt_old = 32'd0;
  logic        Stall = 1'b0;
  logic        Flush = 1'b0;
  logic [4:0]  Rd_addr;
  logic [31:0] Rd_in;
  logic [3:0]  Rd_write_byte_en;
  logic        Fwd_valid;
  logic [4:0]  Fwd_addr;
  logic [31:0] Fwd_data;
  logic [31:0] Wb_count;

  mips_wb_stage dut (
    .Clk              (Clk),
    .Rst_n            (Rst_n),
    .Mem_valid        (Mem_valid),
    .Mem_load_type    (Mem_load_type),
    .Mem_reg_write    (Mem_reg_write),
    .Mem_rd_addr      (Mem_rd_addr),
    .Mem_alu_result   (Mem_alu_result),
    .Mem_rdata        (Mem_rdata),
    .Mem_rt_old       (Mem_rt_old),
    .Stall            (Stall),
    .Flush            (Flush),
    .Rd_addr          (Rd_addr),
    .Rd_in            (Rd_in),
    .Rd_write_byte_en (Rd_write_byte_en),
    .Fwd_valid        (Fwd_valid),
    .Fwd_addr         (Fwd_addr),
    .Fwd_data         (Fwd_data),
    .Wb_count         (Wb_count)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int passed = 0;

  // Reference model: the entry on the WB outputs and how many cycles it has been shown.
  bit          m_valid;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic [3:0]  m_en;
  logic [31:0] m_rtold;
  int          m_age;
  logic [31:0] m_count;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic void model_reset();
    m_valid = 1'b0;
    m_addr  = '0;
    m_data  = '0;
    m_en    = '0;
    m_rtold = '0;
    m_age   = 0;
    m_count = '0;
  endfunction

  // Plain-arithmetic statement of the load rules.
  function automatic void ref_align(input logic [2:0] lt, input logic rw, input logic [4:0] rd,
                                    input logic [31:0] alu, input logic [31:0] rdata,
                                    output logic [31:0] d, output logic [3:0] e);
    int   off;
    logic [31:0] b;
    logic [31:0] h;
    off = int'(alu[1:0]);
    b = (rdata >> (24 - 8 * off)) & 32'hFF;
    h = (off >= 2) ? (rdata & 32'hFFFF) : (rdata >> 16);
    d = 32'd0;
    e = 4'd0;
    case (lt)
      3'd0: begin d = alu; e = rw ? 4'hF : 4'h0; end
      3'd1: begin d = (b >= 32'h80) ? (b | 32'hFFFFFF00) : b; e = 4'hF; end
      3'd2: begin d = b; e = 4'hF; end
      3'd3: begin d = (h >= 32'h8000) ? (h | 32'hFFFF0000) : h; e = 4'hF; end
      3'd4: begin d = h; e = 4'hF; end
      3'd5: begin d = rdata; e = 4'hF; end
`ifdef MIPS_WB_LWLR_EN
      3'd6: begin d = rdata << (8 * off); e = 4'hF << off; end
      3'd7: begin d = rdata >> (8 * (3 - off)); e = 4'hF >> (3 - off); end
`endif
      default: begin d = 32'd0; e = 4'd0; end
    endcase
    if (rd == 5'd0) e = 4'd0;
  endfunction

  function automatic void model_step();
    logic [31:0] d;
    logic [3:0]  e;
    if (Stall) begin
      m_age++;
    end else if (Flush) begin
      m_valid = 1'b0;
      m_age   = 0;
    end else begin
      ref_align(Mem_load_type, Mem_reg_write, Mem_rd_addr, Mem_alu_result, Mem_rdata, d, e);
      m_valid = Mem_valid;
      m_addr  = Mem_rd_addr;
      m_data  = d;
      m_en    = e;
      m_rtold = Mem_rt_old;
      m_age   = 0;
      if (Mem_valid) m_count = m_count + 32'd1;
    end
  endfunction

  // One rising edge; the model consumes the inputs the DUT just captured.
  task automatic cycle();
    @(posedge Clk);
    #1;
    if (Rst_n) model_step();
  endtask

  task automatic drive(input logic mv, input logic [2:0] lt, input logic rw, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] rdata, input logic [31:0] rtold,
                       input logic st, input logic fl);
    Mem_valid = mv; Mem_load_type = lt; Mem_reg_write = rw; Mem_rd_addr = rd;
    Mem_alu_result = alu; Mem_rdata = rdata; Mem_rt_old = rtold; Stall = st; Flush = fl;
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_addr"}, 32'(Rd_addr), 32'd0);
    check({tag, "_rd_in"}, Rd_in, 32'd0);
    check({tag, "_en"}, 32'(Rd_write_byte_en), 32'd0);
    check({tag, "_fwd_valid"}, 32'(Fwd_valid), 32'd0);
    check({tag, "_fwd_addr"}, 32'(Fwd_addr), 32'd0);
    check({tag, "_fwd_data"}, Fwd_data, 32'd0);
    check({tag, "_count"}, Wb_count, 32'd0);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear before any clock.
  task automatic mid_cycle_reset(input string tag);
    #2;
    Rst_n = 1'b0;
    #1;
    check_all_zero(tag);
    model_reset();
    cycle();
    Rst_n = 1'b1;
  endtask

  // Per-cycle comparison against the model.
  always @(negedge Clk) begin : cmp
    logic [3:0]  exp_we;
    logic [31:0] exp_fd;
    exp_we = (m_valid && m_age == 0) ? m_en : 4'd0;
    check("cyc_we", 32'(Rd_write_byte_en), 32'(exp_we));
    check("cyc_fwd_valid", 32'(Fwd_valid), 32'(m_valid && m_en != 4'd0));
    check("cyc_count", Wb_count, m_count);
    if (m_valid && m_en != 4'd0) begin
      for (int i = 0; i < 4; i++)
        exp_fd[8*i +: 8] = m_en[i] ? m_data[8*i +: 8] : m_rtold[8*i +: 8];
      check("cyc_rd_addr", 32'(Rd_addr), 32'(m_addr));
      check("cyc_rd_in", Rd_in, m_data);
      check("cyc_fwd_addr", 32'(Fwd_addr), 32'(m_addr));
      check("cyc_fwd_data", Fwd_data, exp_fd);
    end
  end

  initial begin
    model_reset();
    #2;
    check_all_zero("por");
    cycle();
    cycle();
    Rst_n = 1'b1;

    // LB off 2
    drive(1'b1, LB, 1'b0, 5'd5, 32'h0000_1002, 32'hAABBCCDD, 32'h0, 1'b0, 1'b0);
    cycle(); idle();
    check("lb_rd_in", Rd_in, 32'hFFFFFFCC);
    check("lb_en", 32'(Rd_write_byte_en), 32'hF);
    check("lb_rd_addr", 32'(Rd_addr), 32'd5);
    check("lb_count", Wb_count, 32'd1);

    // LHU off 3 (off[0] ignored)
    drive(1'b1, LHU, 1'b0, 5'd6, 32'h0000_2003, 32'hAABBCCDD, 32'h0, 1'b0, 1'b0);
    cycle(); idle();
    check("lhu_rd_in", Rd_in, 32'h0000CCDD);
    check("lhu_count", Wb_count, 32'd2);

    // LWL off 1
    drive(1'b1, LWL, 1'b0, 5'd7, 32'h0000_0001, 32'hAABBCCDD, 32'h11112345, 1'b0, 1'b0);
    cycle(); idle();
`ifdef MIPS_WB_LWLR_EN
    check("lwl_rd_in", Rd_in, 32'hBBCCDD00);
    check("lwl_en", 32'(Rd_write_byte_en), 32'hE);
    check("lwl_fwd_data", Fwd_data, 32'hBBCCDD45);
`else
    check("lwl_en", 32'(Rd_write_byte_en), 32'h0);
    check("lwl_fwd_valid", 32'(Fwd_valid), 32'd0);
`endif
    check("lwl_count", Wb_count, 32'd3);

    // LWR off 0
    drive(1'b1, LWR, 1'b0, 5'd7, 32'h0000_0000, 32'hAABBCCDD, 32'h11112345, 1'b0, 1'b0);
    cycle(); idle();
`ifdef MIPS_WB_LWLR_EN
    check("lwr_rd_in", Rd_in, 32'h000000AA);
    check("lwr_en", 32'(Rd_write_byte_en), 32'h1);
    check("lwr_fwd_data", Fwd_data, 32'h111123AA);
`else
    check("lwr_en", 32'(Rd_write_byte_en), 32'h0);
    check("lwr_fwd_valid", 32'(Fwd_valid), 32'd0);
`endif
    check("lwr_count", Wb_count, 32'd4);

    // ALU write to $zero
    drive(1'b1, LOAD_NONE, 1'b1, 5'd0, 32'h0000_1234, 32'h0, 32'h0, 1'b0, 1'b0);
    cycle(); idle();
    check("r0_en", 32'(Rd_write_byte_en), 32'h0);
    check("r0_fwd_valid", 32'(Fwd_valid), 32'd0);

    // LW to rd 9, then held three cycles (one with Flush too)
    drive(1'b1, LW, 1'b0, 5'd9, 32'h0000_0100, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
    cycle();
    check("lw_en", 32'(Rd_write_byte_en), 32'hF);
    check("lw_count", Wb_count, 32'd6);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, LB, 1'b0, 5'd4, $urandom, $urandom, $urandom, 1'b1, (k == 1));
      cycle();
      check("hold_en", 32'(Rd_write_byte_en), 32'h0);
      check("hold_fwd_valid", 32'(Fwd_valid), 32'd1);
      check("hold_fwd_addr", 32'(Fwd_addr), 32'd9);
      check("hold_count", Wb_count, 32'd6);
    end
    drive(1'b1, LW, 1'b0, 5'd4, 32'h0, 32'h12345678, 32'h0, 1'b0, 1'b1);
    cycle(); idle();
    check("flush_en", 32'(Rd_write_byte_en), 32'h0);
    check("flush_fwd_valid", 32'(Fwd_valid), 32'd0);
    check("flush_count", Wb_count, 32'd6);

    // Reset in the middle of a write cycle
    drive(1'b1, LW, 1'b0, 5'd3, 32'h0, 32'h55AA55AA, 32'h0, 1'b0, 1'b0);
    cycle(); idle();
    check("pre_rst_en", 32'(Rd_write_byte_en), 32'hF);
    mid_cycle_reset("rst_mid");

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      drive(($urandom_range(3, 0) != 0), 3'($urandom_range(7, 0)), 1'($urandom),
            ($urandom_range(3, 0) == 0) ? 5'd0 : 5'($urandom), $urandom, $urandom, $urandom,
            ($urandom_range(4, 0) == 0), ($urandom_range(7, 0) == 0));
      cycle();
      if ($urandom_range(99, 0) == 0) mid_cycle_reset("rst_rand");
    end
    idle();
    cycle();
    cycle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
